// File: rtl/simproc_boot_ctrl.sv
// simproc_boot_ctrl: UART command sequencer that loads instruction memory, runs the CPU and reports status.
// Define SIMPROC_BOOT_CSUM_EN to require a trailing checksum byte after every load (replies 'K' or 'E').
module simproc_boot_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    input  logic              cpu_halt,
    input  logic              cpu_done,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    // Handshakes: rx is a 1-cycle strobe with no backpressure (bytes arriving in RESP are dropped);
    // tx transfers a byte on any cycle with tx_valid && tx_ready, and tx_data is stable while waiting.

    localparam logic [7:0] CMD_LOAD   = 8'h4C;
    localparam logic [7:0] CMD_RUN    = 8'h52;
    localparam logic [7:0] CMD_STATUS = 8'h53;
    localparam logic [7:0] CMD_ABORT  = 8'h41;
    localparam logic [7:0] RSP_OK     = 8'h4B;
    localparam logic [7:0] RSP_BAD    = 8'h3F;
    localparam logic [7:0] RSP_DONE   = 8'h44;
    localparam logic [7:0] RSP_HALT   = 8'h48;
`ifdef SIMPROC_BOOT_CSUM_EN
    localparam logic [7:0] RSP_ERR    = 8'h45;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        L_ADDR = 3'd1,
        L_LEN  = 3'd2,
        L_DATA = 3'd3,
`ifdef SIMPROC_BOOT_CSUM_EN
        L_CSUM = 3'd6,
`endif
        RUN    = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic [8:0]        remaining;
    logic              overrun;
    logic              status_reply;
    logic              resp_load;
    logic              resp_status;
    logic [7:0]        resp_byte;

`ifdef SIMPROC_BOOT_CSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 8'h00;
        end else if (rx_valid && state == L_ADDR) begin
            csum <= rx_data;
        end else if (rx_valid && (state == L_LEN || state == L_DATA)) begin
            csum <= csum + rx_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        resp_load   = 1'b0;
        resp_status = 1'b0;
        resp_byte   = 8'h00;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_LOAD: state_next = L_ADDR;
                        CMD_RUN:  state_next = RUN;
                        CMD_STATUS: begin
                            state_next  = RESP;
                            resp_load   = 1'b1;
                            resp_status = 1'b1;
                            resp_byte   = {5'b0, overrun, cpu_done, cpu_halt};
                        end
                        default: begin
                            state_next = RESP;
                            resp_load  = 1'b1;
                            resp_byte  = RSP_BAD;
                        end
                    endcase
                end
            end
            L_ADDR: if (rx_valid) state_next = L_LEN;
            L_LEN:  if (rx_valid) state_next = L_DATA;
            L_DATA: begin
                if (rx_valid && remaining == 9'd1) begin
`ifdef SIMPROC_BOOT_CSUM_EN
                    state_next = L_CSUM;
`else
                    state_next = RESP;
                    resp_load  = 1'b1;
                    resp_byte  = RSP_OK;
`endif
                end
            end
`ifdef SIMPROC_BOOT_CSUM_EN
            L_CSUM: begin
                // csum already includes the last data byte here
                if (rx_valid) begin
                    state_next = RESP;
                    resp_load  = 1'b1;
                    resp_byte  = (rx_data == csum) ? RSP_OK : RSP_ERR;
                end
            end
`endif
            RUN: begin
                if (rx_valid && rx_data == CMD_ABORT) begin
                    state_next = RESP;
                    resp_load  = 1'b1;
                    resp_byte  = CMD_ABORT;
                end else if (cpu_done) begin
                    state_next = RESP;
                    resp_load  = 1'b1;
                    resp_byte  = RSP_DONE;
                end else if (cpu_halt) begin
                    state_next = RESP;
                    resp_load  = 1'b1;
                    resp_byte  = RSP_HALT;
                end
            end
            RESP: if (tx_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 8'h00;
            wr_ptr       <= '0;
            remaining    <= 9'd0;
            tx_data      <= 8'h00;
            status_reply <= 1'b0;
            overrun      <= 1'b0;
            cpu_run      <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            cpu_run <= (state_next == RUN);
            if (resp_load) begin
                tx_data      <= resp_byte;
                status_reply <= resp_status;
            end
            if (rx_valid) begin
                case (state)
                    L_ADDR: wr_ptr <= ADDR_W'(rx_data);
                    L_LEN:  remaining <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    L_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_ptr;
                        mem_wdata <= rx_data;
                        wr_ptr    <= wr_ptr + ADDR_W'(1);
                        remaining <= remaining - 9'd1;
                    end
                    default: ;
                endcase
            end
            // A byte dropped on the same cycle as a status handshake still leaves overrun set
            if (state == RESP && tx_ready && status_reply) overrun <= 1'b0;
            if (state == RESP && rx_valid) overrun <= 1'b1;
        end
    end

    assign tx_valid  = (state == RESP);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_simproc_boot_ctrl.sv
// Self-checking bench for simproc_boot_ctrl: a scoreboard of expected memory writes and tx bytes.
module tb_simproc_boot_ctrl;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_run;
    logic              cpu_halt;
    logic              cpu_done;
    logic              busy;
    logic [2:0]        dbg_state;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [7:0]  pay_q[$];

    simproc_boot_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .cpu_halt(cpu_halt), .cpu_done(cpu_done),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // One clock: scoreboard sampling on the falling edge, return just after the rising edge.
    task automatic tick();
        logic [15:0] ew;
        logic [7:0]  et;
        @(negedge clk);
        if (rst_n) begin
            if (mem_we) begin
                total++;
                if (exp_wr_q.size() == 0) begin
                    bad++;
                    $display("FAIL mem_write_unexpected: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
                end else begin
                    ew = exp_wr_q.pop_front();
                    if ({mem_addr, mem_wdata} !== ew) begin
                        bad++;
                        $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                                 mem_addr, mem_wdata, ew[15:8], ew[7:0]);
                    end
                end
            end
            if (tx_valid && tx_ready) begin
                total++;
                if (exp_tx_q.size() == 0) begin
                    bad++;
                    $display("FAIL tx_unexpected: got %h, required no byte", tx_data);
                end else begin
                    et = exp_tx_q.pop_front();
                    if (tx_data !== et) begin
                        bad++;
                        $display("FAIL tx_byte: got %h, required %h", tx_data, et);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_tx_q.size() != 0 || exp_wr_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (exp_tx_q.size() != 0 || exp_wr_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d tx and %0d writes pending, required 0",
                     exp_tx_q.size(), exp_wr_q.size());
            exp_tx_q.delete();
            exp_wr_q.delete();
        end
        tick();
    endtask

    task automatic send_load(input logic [7:0] base, input logic [7:0] len_byte);
        int         n;
        logic [7:0] sum;
        logic [7:0] a;
        logic [7:0] b;
        n   = (len_byte == 8'h00) ? 256 : int'(len_byte);
        sum = base + len_byte;
        a   = base;
        send_byte(8'h4C);
        send_byte(base);
        send_byte(len_byte);
        for (int i = 0; i < n; i++) begin
            b = pay_q.pop_front();
            exp_wr_q.push_back({a, b});
            send_byte(b);
            total++;
            if (mem_we !== 1'b1) begin
                bad++;
                $display("FAIL mem_we_latency: got %b, required 1 (byte %0d)", mem_we, i);
            end
            a   = a + 8'h01;
            sum = sum + b;
        end
        exp_tx_q.push_back(8'h4B);
`ifdef SIMPROC_BOOT_CSUM_EN
        send_byte(sum);
`endif
        drain(20);
    endtask

    task automatic test_reset();
        total++;
        if ({tx_valid, tx_data, mem_we, mem_addr, mem_wdata, cpu_run, busy, dbg_state} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got tv=%b td=%h we=%b a=%h d=%h run=%b busy=%b st=%0d, required all 0",
                     tx_valid, tx_data, mem_we, mem_addr, mem_wdata, cpu_run, busy, dbg_state);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        exp_tx_q.push_back(8'h00);
        send_byte(8'h53);
        drain(10);
    endtask

    task automatic test_load();
        pay_q = '{8'hA1, 8'hB2, 8'hC3};
        send_load(8'h10, 8'h03);
    endtask

    task automatic test_wrap();
        pay_q = '{8'h11, 8'h22};
        send_load(8'hFF, 8'h02);
        for (int i = 0; i < 256; i++) pay_q.push_back(8'($urandom_range(0, 255)));
        send_load(8'h40, 8'h00);
    endtask

    task automatic test_run();
        logic [7:0] exp_b;
        for (int c = 0; c < 3; c++) begin
            send_byte(8'h52);
            total++;
            if (cpu_run !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL run_start case%0d: got run=%b busy=%b, required 1/1", c, cpu_run, busy);
            end
            repeat (50) tick();
            total++;
            if (cpu_run !== 1'b1) begin
                bad++;
                $display("FAIL run_hold case%0d: got %b, required 1", c, cpu_run);
            end
            cpu_done = (c != 1);
            cpu_halt = (c != 0);
            exp_b    = (c == 1) ? 8'h48 : 8'h44;
            exp_tx_q.push_back(exp_b);
            tick();
            total++;
            if (cpu_run !== 1'b0 || tx_valid !== 1'b1) begin
                bad++;
                $display("FAIL run_stop case%0d: got run=%b tx_valid=%b, required 0/1", c, cpu_run, tx_valid);
            end
            cpu_done = 1'b0;
            cpu_halt = 1'b0;
            drain(10);
        end
    endtask

    task automatic test_abort_overrun();
        send_byte(8'h52);
        repeat (5) tick();
        tx_ready = 1'b0;
        exp_tx_q.push_back(8'h41);
        send_byte(8'h41);
        total++;
        if (cpu_run !== 1'b0 || tx_valid !== 1'b1) begin
            bad++;
            $display("FAIL abort: got run=%b tx_valid=%b, required 0/1", cpu_run, tx_valid);
        end
        repeat (5) tick();
        send_byte(8'h55);
        repeat (14) tick();
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            bad++;
            $display("FAIL tx_stall_hold: got tv=%b td=%h, required 1/41", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        drain(10);
        exp_tx_q.push_back(8'h04);
        send_byte(8'h53);
        drain(10);
        exp_tx_q.push_back(8'h00);
        send_byte(8'h53);
        drain(10);
        // abort in the same cycle as done must still reply 'A'
        send_byte(8'h52);
        repeat (3) tick();
        exp_tx_q.push_back(8'h41);
        cpu_done = 1'b1;
        send_byte(8'h41);
        cpu_done = 1'b0;
        drain(10);
    endtask

    task automatic test_status_bad_cmd();
        cpu_halt = 1'b1;
        exp_tx_q.push_back(8'h01);
        send_byte(8'h53);
        cpu_done = 1'b1;
        drain(10);
        exp_tx_q.push_back(8'h03);
        send_byte(8'h53);
        cpu_done = 1'b0;
        cpu_halt = 1'b0;
        drain(10);
        exp_tx_q.push_back(8'h3F);
        send_byte(8'h7A);
        total++;
        if (tx_valid !== 1'b1) begin
            bad++;
            $display("FAIL cmd_latency: got tx_valid=%b, required 1", tx_valid);
        end
        drain(10);
    endtask

    task automatic test_reset_mid_load();
        tx_ready = 1'b0;
        exp_tx_q.push_back(8'h3F);
        send_byte(8'h00);
        send_byte(8'h55);
        tx_ready = 1'b1;
        drain(10);
        send_byte(8'h4C);
        send_byte(8'h20);
        send_byte(8'h03);
        exp_wr_q.push_back({8'h20, 8'hAA});
        send_byte(8'hAA);
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({tx_valid, tx_data, mem_we, mem_addr, mem_wdata, cpu_run, busy, dbg_state} !== '0) begin
            bad++;
            $display("FAIL reset_mid_load: got tv=%b td=%h we=%b a=%h d=%h run=%b busy=%b st=%0d, required all 0",
                     tx_valid, tx_data, mem_we, mem_addr, mem_wdata, cpu_run, busy, dbg_state);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        exp_tx_q.push_back(8'h00);
        send_byte(8'h53);
        drain(10);
    endtask

`ifdef SIMPROC_BOOT_CSUM_EN
    task automatic test_csum();
        pay_q = '{8'h05};
        send_load(8'h00, 8'h01);
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h01);
        exp_wr_q.push_back({8'h00, 8'h05});
        send_byte(8'h05);
        exp_tx_q.push_back(8'h45);
        send_byte(8'h07);
        drain(10);
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        cpu_halt = 1'b0;
        cpu_done = 1'b0;
        #1;
        test_reset();
        test_load();
        test_wrap();
        test_run();
        test_abort_overrun();
        test_status_bad_cmd();
        test_reset_mid_load();
`ifdef SIMPROC_BOOT_CSUM_EN
        test_csum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
